// File: rtl/ifetch_ctrl_pkg.sv
// Shared constants and state encodings for the instruction fetch sequencer.
package ifetch_ctrl_pkg;

  localparam int  ADDR_WIDTH = 32;
  localparam int  INST_WIDTH = 32;
  localparam logic ENABLE  = 1'b1;
  localparam logic DISABLE = 1'b0;
  localparam logic [ADDR_WIDTH-1:0] NULL = '0;

  typedef enum logic [1:0] {
    IF_IDLE    = 2'd0,
    IF_WAIT    = 2'd1,
    IF_DISCARD = 2'd2
  } if_state_e;

endpackage

// File: rtl/ifetch_ctrl_if.sv
// Fetch-side bus: instruction-queue push port and memory-controller request port.
// iq: iq_en_out is a one-cycle push strobe; iq_rdy_in promises room for two more pushes.
// mem: mem_req_out is a level held until the one-cycle mem_done_in strobe; no abort, one outstanding.
interface ifetch_ctrl_if #(
  parameter int ADDR_W = 32
) ();
  logic              iq_en_out;
  logic [ADDR_W-1:0] iq_inst_out;
  logic [ADDR_W-1:0] iq_pc_out;
  logic              iq_rdy_in;
  logic              mem_req_out;
  logic [ADDR_W-1:0] mem_addr_out;
  logic              mem_done_in;
  logic [ADDR_W-1:0] mem_data_in;

  modport master (
    output iq_en_out, iq_inst_out, iq_pc_out, mem_req_out, mem_addr_out,
    input  iq_rdy_in, mem_done_in, mem_data_in
  );

  modport slave (
    input  iq_en_out, iq_inst_out, iq_pc_out, mem_req_out, mem_addr_out,
    output iq_rdy_in, mem_done_in, mem_data_in
  );
endinterface

// File: rtl/ifetch_ctrl_icache_dm.sv
// Direct-mapped one-word-per-line instruction cache: combinational lookup, single write port.
module icache_dm #(
  parameter int INDEX_W = 6,
  parameter int ADDR_W  = 32,
  localparam int TAG_W  = ADDR_W - INDEX_W - 2,
  localparam int LINES  = 1 << INDEX_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [INDEX_W-1:0] rd_index,
  input  logic [TAG_W-1:0]   rd_tag,
  output logic               rd_hit,
  output logic [ADDR_W-1:0]  rd_data,
  input  logic               wr_en,
  input  logic [INDEX_W-1:0] wr_index,
  input  logic [TAG_W-1:0]   wr_tag,
  input  logic [ADDR_W-1:0]  wr_data
);

  logic [LINES-1:0]  valid_q;
  logic [TAG_W-1:0]  tag_q  [LINES];
  logic [ADDR_W-1:0] data_q [LINES];

  // Only valid bits need clearing; tag/data are qualified by valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
    end else if (wr_en) begin
      valid_q[wr_index] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      tag_q[wr_index]  <= wr_tag;
      data_q[wr_index] <= wr_data;
    end
  end

  assign rd_hit  = valid_q[rd_index] && (tag_q[rd_index] == rd_tag);
  assign rd_data = data_q[rd_index];

endmodule

// File: rtl/ifetch_ctrl.sv
// Fetch sequencer: holds the PC, looks it up in the I-cache, fetches misses from memory,
// pushes {inst, pc} into the instruction queue and redirects on ROB flush.
module ifetch_ctrl
  import ifetch_ctrl_pkg::*;
#(
  parameter logic [31:0] RESET_PC       = 32'h0,
  parameter int          ICACHE_INDEX_W = 6,
  parameter int          ADDR_W         = 32
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              rdy_in,
  input  logic              rob_flush_in,
  input  logic [ADDR_W-1:0] rob_target_pc_in,
  ifetch_ctrl_if.master     bus,
  output logic [1:0]        state_dbg
);

  localparam int TAG_LO = ICACHE_INDEX_W + 2;

  if_state_e         state_q, state_n;
  logic [ADDR_W-1:0] pc_q, pc_n;
  logic              iq_en_q, iq_en_n;
  logic [ADDR_W-1:0] iq_inst_q, iq_inst_n;
  logic [ADDR_W-1:0] iq_pc_q, iq_pc_n;
  logic              req_q, req_n;
  logic [ADDR_W-1:0] addr_q, addr_n;
  logic              fill;
  logic              hit;
  logic [ADDR_W-1:0] hit_data;

  // Fills use the request address, since the PC may already be redirected in DISCARD.
  icache_dm #(.INDEX_W(ICACHE_INDEX_W), .ADDR_W(ADDR_W)) u_icache (
    .clk      (clk_in),
    .rst_n    (rst_in),
    .rd_index (pc_q[TAG_LO-1:2]),
    .rd_tag   (pc_q[ADDR_W-1:TAG_LO]),
    .rd_hit   (hit),
    .rd_data  (hit_data),
    .wr_en    (fill),
    .wr_index (addr_q[TAG_LO-1:2]),
    .wr_tag   (addr_q[ADDR_W-1:TAG_LO]),
    .wr_data  (bus.mem_data_in)
  );

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q   <= IF_IDLE;
      pc_q      <= ADDR_W'(RESET_PC);
      iq_en_q   <= DISABLE;
      iq_inst_q <= NULL;
      iq_pc_q   <= NULL;
      req_q     <= DISABLE;
      addr_q    <= NULL;
    end else begin
      state_q   <= state_n;
      pc_q      <= pc_n;
      iq_en_q   <= iq_en_n;
      iq_inst_q <= iq_inst_n;
      iq_pc_q   <= iq_pc_n;
      req_q     <= req_n;
      addr_q    <= addr_n;
    end
  end

  always_comb begin
    state_n   = state_q;
    pc_n      = pc_q;
    iq_en_n   = DISABLE;
    iq_inst_n = iq_inst_q;
    iq_pc_n   = iq_pc_q;
    req_n     = req_q;
    addr_n    = addr_q;
    fill      = DISABLE;
    if (rdy_in) begin
      unique case (state_q)
        IF_IDLE: begin
          if (rob_flush_in) begin
            pc_n = rob_target_pc_in;
          end else if (bus.iq_rdy_in) begin
            if (hit) begin
              iq_en_n   = ENABLE;
              iq_inst_n = hit_data;
              iq_pc_n   = pc_q;
              pc_n      = pc_q + ADDR_W'(4);
            end else begin
              req_n   = ENABLE;
              addr_n  = pc_q;
              state_n = IF_WAIT;
            end
          end
        end
        IF_WAIT: begin
          if (bus.mem_done_in) begin
            fill    = ENABLE;
            req_n   = DISABLE;
            state_n = IF_IDLE;
            if (rob_flush_in) begin
              pc_n = rob_target_pc_in;
            end else begin
              // Queue slack guarantees room, so this push ignores iq_rdy_in.
              iq_en_n   = ENABLE;
              iq_inst_n = bus.mem_data_in;
              iq_pc_n   = pc_q;
              pc_n      = pc_q + ADDR_W'(4);
            end
          end else if (rob_flush_in) begin
            pc_n    = rob_target_pc_in;
            state_n = IF_DISCARD;
          end
        end
        IF_DISCARD: begin
          if (rob_flush_in) pc_n = rob_target_pc_in;
          if (bus.mem_done_in) begin
            fill    = ENABLE;
            req_n   = DISABLE;
            state_n = IF_IDLE;
          end
        end
        default: state_n = IF_IDLE;
      endcase
    end
  end

  assign bus.iq_en_out    = iq_en_q;
  assign bus.iq_inst_out  = iq_inst_q;
  assign bus.iq_pc_out    = iq_pc_q;
  assign bus.mem_req_out  = req_q;
  assign bus.mem_addr_out = addr_q;
  assign state_dbg        = state_q;

endmodule

// File: doc/ifetch_ctrl.md
Name: ifetch_ctrl

Overview:
- Fetch sequencer that produces the instruction stream for the instruction queue.
- Holds the fetch PC and looks it up in a direct-mapped instruction cache.
- On a miss, requests one 32-bit word from the memory controller and fills the cache.
- Pushes {inst, pc} into the queue under its ready backpressure, and redirects the PC on a ROB flush, dropping any in-flight fetch.

Parameters:
- RESET_PC, 32'h0, fetch address after reset.
- ICACHE_INDEX_W, 6, log2 of cache lines (64 one-word lines).
- ADDR_W, 32, address and instruction width (matches the shared address/instruction widths).

Ports:
- clk_in  input  1  clock; all state on rising edge.
- rst_in  input  1  asynchronous active-low reset.
- rdy_in  input  1  global stall; low = hold all state, no new pushes.
- rob_flush_in  input  1  mispredict/exception flush pulse.
- rob_target_pc_in  input  ADDR_W  redirect PC, valid with rob_flush_in.
- iq_rdy_in  input  1  queue has at least 2 free slots.
- iq_en_out  output  1  one-cycle push strobe to the queue.
- iq_inst_out  output  ADDR_W  instruction pushed.
- iq_pc_out  output  ADDR_W  PC of the pushed instruction.
- mem_req_out  output  1  fetch request to the memory controller; level, held until done.
- mem_addr_out  output  ADDR_W  word address of the request.
- mem_done_in  input  1  one-cycle completion strobe.
- mem_data_in  input  ADDR_W  fetched word, valid with mem_done_in.

Behaviour:
- Reset (rst_in low, asynchronous):
  - pc=RESET_PC, state=IDLE, all cache valid bits=0.
  - iq_en_out=0, iq_inst_out=0, iq_pc_out=0, mem_req_out=0, mem_addr_out=0.
- iq_en_out defaults to 0 every cycle and is a single-cycle pulse.
- rdy_in low: no state change, iq_en_out=0, mem_req_out holds its value, cache not written.
- Address split: index=pc[ICACHE_INDEX_W+1:2]; tag=pc[ADDR_W-1:ICACHE_INDEX_W+2]. pc[1:0] is always 00, and flush targets are word-aligned by contract.
- States: IDLE, WAIT, DISCARD.
- IDLE, no flush, iq_rdy_in=1:
  - Hit: next cycle iq_en_out=1, iq_inst_out=line data, iq_pc_out=pc; pc<=pc+4 (wraps mod 2^32). Throughput is 1 instruction/cycle on hits.
  - Miss: mem_req_out<=1, mem_addr_out<=pc, go to WAIT.
- IDLE with iq_rdy_in=0: no lookup, no push.
- WAIT, on mem_done_in without flush:
  - Write line {valid=1, tag, mem_data_in}.
  - iq_en_out=1 with mem_data_in and pc; pc<=pc+4; mem_req_out<=0; go to IDLE.
  - This push ignores iq_rdy_in; the 2-slot slack in iq_rdy_in guarantees space.
- Flush (highest priority, any state):
  - pc<=rob_target_pc_in, no push that cycle.
  - IDLE: stays IDLE; lookup resumes next cycle.
  - WAIT with no done: go to DISCARD. mem_req_out stays high (the memory controller cannot abort).
  - WAIT with mem_done_in in the same cycle: fill the cache, no push, mem_req_out<=0, go to IDLE.
- DISCARD:
  - On mem_done_in: fill the cache (memory is read-only for instructions), no push, mem_req_out<=0, go to IDLE.
  - A further flush in DISCARD only updates pc.
- mem_addr_out changes only when a request is issued (IDLE to WAIT).
- Never more than one outstanding memory request.

Decomposition:
- Shared header holds the existing width macros, ENABLE/DISABLE/NULL, and new state encodings IF_IDLE=2'd0, IF_WAIT=2'd1, IF_DISCARD=2'd2.
- One sub-module, icache_dm:
  - Arrays for valid, tag and data.
  - Combinational read of hit and data by index/tag.
  - Synchronous single write port.
  - Async active-low clear of valid bits.
- ifetch_ctrl holds the PC, the FSM and output registers.

Test Plan:
- Cold start, RESET_PC=0: memory returns 32'h00000013 after 3 cycles for 0x0 and 0x4 -> two mem_req_out transactions at addr 0x0 then 0x4; pushes (0x00000013, pc 0x0) then (…, 0x4).
- Loop refetch: flush to 0x0 after the lines are filled -> no mem_req_out; pushes pc 0x0 and 0x4 on consecutive cycles.
- Flush in WAIT: miss at 0x8, flush to 0x100 before done -> mem_req_out stays high until done, no push for 0x8, then a request at 0x100 and a push with pc 0x100.
- Flush coincident with mem_done_in -> no push, next request/lookup at the target, and the 0x8 line is filled (a later fetch of 0x8 hits).
- Backpressure: iq_rdy_in=0 in IDLE for 5 cycles -> no pushes, pc unchanged. A done arriving while iq_rdy_in=0 in WAIT still pushes exactly once.
- Reset mid-WAIT: rst_in low -> all outputs 0 immediately. After release, fetch restarts at RESET_PC and misses (valid bits cleared).
